// File: rtl/gsgate_pipe_pkg.sv
// Shared definitions for the gsgate pipelined logic unit:
// operation encoding and operand slicing helper.
package gsgate_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_BUF  = 3'd7
  } op_e;

  // Bit offset of operand k inside a packed N*W operand bus.
  function automatic int unsigned operand_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/gsgate_pipe_if.sv
// Handshake bundle for gsgate_pipe: input side (op/operands) and output side
// (result, change flag, change counter).
interface gsgate_pipe_if #(
  parameter int unsigned W  = 8,
  parameter int unsigned N  = 2,
  parameter int unsigned CW = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     op;
  logic [N*W-1:0] a;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   y;
  logic           out_changed;
  logic [CW-1:0]  change_count;

  modport master (
    output in_valid, op, a, out_ready,
    input  in_ready, out_valid, y, out_changed, change_count
  );

  modport slave (
    input  in_valid, op, a, out_ready,
    output in_ready, out_valid, y, out_changed, change_count
  );
endinterface

// File: rtl/gsgate_pipe_reduce.sv
// Combinational bitwise reduction of N W-bit operands under a 3-bit op select.
module gsgate_reduce
  import gsgate_pkg::*;
#(
  parameter int unsigned W = 8,
  parameter int unsigned N = 2
) (
  input  logic [2:0]     op,
  input  logic [N*W-1:0] a,
  output logic [W-1:0]   y
);

  logic [W-1:0] operand [N];

  for (genvar k = 0; k < N; k++) begin : g_slice
    assign operand[k] = a[operand_lsb(k, W) +: W];
  end

  logic [W-1:0] and_r;
  logic [W-1:0] or_r;
  logic [W-1:0] xor_r;

  always_comb begin
    and_r = '1;
    or_r  = '0;
    xor_r = '0;
    for (int unsigned k = 0; k < N; k++) begin
      and_r = and_r & operand[k];
      or_r  = or_r  | operand[k];
      xor_r = xor_r ^ operand[k];
    end
  end

  always_comb begin
    y = '0;
    case (op_e'(op))
      OP_AND:  y = and_r;
      OP_OR:   y = or_r;
      OP_XOR:  y = xor_r;
      OP_NAND: y = ~and_r;
      OP_NOR:  y = ~or_r;
      OP_XNOR: y = ~xor_r;
      OP_NOT:  y = ~operand[0];
      OP_BUF:  y = operand[0];
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/gsgate_pipe.sv
// Two-stage registered logic unit with valid/ready backpressure, change
// detection against the last delivered result and a saturating change counter.
module gsgate_pipe
  import gsgate_pkg::*;
#(
  parameter int unsigned W  = 8,
  parameter int unsigned N  = 2,
  parameter int unsigned CW = 16
) (
  input  logic         clk,
  input  logic         rst,
  gsgate_pipe_if.slave bus
);

  logic           s1_valid;
  logic [2:0]     s1_op;
  logic [N*W-1:0] s1_a;
  logic           s2_valid;
  logic [W-1:0]   s2_y;
  logic           s2_changed;
  logic [W-1:0]   prev;
  logic [CW-1:0]  count;

  logic           s2_adv;
  logic           s1_adv;
  logic           in_ready;
  logic           in_hs;
  logic           out_hs;
  logic [W-1:0]   result;
  logic [W-1:0]   cmp_ref;

  gsgate_reduce #(
    .W (W),
    .N (N)
  ) u_reduce (
    .op (s1_op),
    .a  (s1_a),
    .y  (result)
  );

  assign s2_adv   = !s2_valid || bus.out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv && !rst;
  assign in_hs    = bus.in_valid && in_ready;
  assign out_hs   = s2_valid && bus.out_ready;

  // A result leaving this cycle becomes prev at the same edge, so compare to it directly.
  assign cmp_ref = out_hs ? s2_y : prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_op      <= '0;
      s1_a       <= '0;
      s2_valid   <= 1'b0;
      s2_y       <= '0;
      s2_changed <= 1'b0;
      prev       <= '0;
      count      <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_hs;
        if (in_hs) begin
          s1_op <= bus.op;
          s1_a  <= bus.a;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_y       <= result;
          s2_changed <= (result != cmp_ref);
        end
      end
      if (out_hs) begin
        prev <= s2_y;
        if (s2_changed && (count != '1)) begin
          count <= count + 1'b1;
        end
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = s2_valid;
  assign bus.y            = s2_y;
  assign bus.out_changed  = s2_changed;
  assign bus.change_count = count;

endmodule

// File: tb/tb_gsgate_pipe.sv
// Randomized scoreboard bench for gsgate_pipe: a wide instance (N=3, CW=16)
// and a narrow one (N=2, CW=2) checked against a per-bit ones-count model.
module tb_gsgate_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gsgate_pipe_if #(.W(8), .N(3), .CW(16)) bm ();
  gsgate_pipe_if #(.W(8), .N(2), .CW(2))  bs ();

  gsgate_pipe #(.W(8), .N(3), .CW(16)) dut_m (.clk(clk), .rst(rst), .bus(bm));
  gsgate_pipe #(.W(8), .N(2), .CW(2))  dut_s (.clk(clk), .rst(rst), .bus(bs));

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Each result bit depends only on how many operands have that bit set.
  function automatic logic [7:0] ref_result(input logic [2:0] op, input logic [23:0] a, input int n);
    logic [7:0] r;
    int ones;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      ones = 0;
      for (int k = 0; k < n; k++) ones += int'(a[k*8+b]);
      case (op)
        3'd0:    r[b] = (ones == n);
        3'd1:    r[b] = (ones > 0);
        3'd2:    r[b] = (ones % 2 == 1);
        3'd3:    r[b] = (ones != n);
        3'd4:    r[b] = (ones == 0);
        3'd5:    r[b] = (ones % 2 == 0);
        3'd6:    r[b] = !a[b];
        default: r[b] = a[b];
      endcase
    end
    return r;
  endfunction

  // Reference state: outstanding results, last delivered value, change count.
  logic [7:0] m_q[$];
  logic [7:0] m_log_y[$];
  logic       m_log_c[$];
  logic [7:0] m_prev = '0;
  int         m_cnt = 0;
  logic       m_ov, m_ir, m_acc;
  logic [7:0] m_y;

  logic [7:0] s_q[$];
  logic [7:0] s_prev = '0;
  int         s_cnt = 0;
  logic       s_ov, s_acc;
  logic [7:0] s_y;
  logic       s_chg;

  task automatic step_m(input bit iv, input logic [2:0] op, input logic [23:0] a, input bit ordy);
    logic [7:0] e;
    @(negedge clk);
    bm.in_valid = iv; bm.op = op; bm.a = a; bm.out_ready = ordy;
    #1;
    m_ov = bm.out_valid; m_ir = bm.in_ready; m_y = bm.y; m_acc = iv && m_ir;
    check_eq("m_change_count", 32'(bm.change_count), 32'(m_cnt));
    if (m_ov && ordy) begin
      if (m_q.size() == 0) begin
        check_eq("m_spurious_output", 32'(1), 32'(0));
      end else begin
        e = m_q.pop_front();
        check_eq("m_y", 32'(bm.y), 32'(e));
        check_eq("m_out_changed", 32'(bm.out_changed), 32'(e != m_prev));
        m_log_y.push_back(bm.y);
        m_log_c.push_back(bm.out_changed);
        if (e != m_prev && m_cnt < 65535) m_cnt++;
        m_prev = e;
      end
    end
    if (m_acc) m_q.push_back(ref_result(op, a, 3));
  endtask

  task automatic step_s(input bit iv, input logic [2:0] op, input logic [15:0] a, input bit ordy);
    logic [7:0] e;
    @(negedge clk);
    bs.in_valid = iv; bs.op = op; bs.a = a; bs.out_ready = ordy;
    #1;
    s_ov = bs.out_valid; s_y = bs.y; s_chg = bs.out_changed; s_acc = iv && bs.in_ready;
    check_eq("s_change_count", 32'(bs.change_count), 32'(s_cnt));
    if (s_ov && ordy) begin
      if (s_q.size() == 0) begin
        check_eq("s_spurious_output", 32'(1), 32'(0));
      end else begin
        e = s_q.pop_front();
        check_eq("s_y", 32'(bs.y), 32'(e));
        check_eq("s_out_changed", 32'(bs.out_changed), 32'(e != s_prev));
        if (e != s_prev && s_cnt < 3) s_cnt++;
        s_prev = e;
      end
    end
    if (s_acc) s_q.push_back(ref_result(op, {8'h00, a}, 2));
  endtask

  task automatic drain_m();
    for (int i = 0; i < 10; i++) begin
      if (m_q.size() == 0) break;
      step_m(1'b0, 3'd0, 24'h0, 1'b1);
    end
    check_eq("m_drain_empty", 32'(m_q.size()), 32'(0));
  endtask

  initial begin
    logic [7:0] tab [8];
    logic [7:0] y_hold;
    logic [2:0] rop;
    logic [23:0] ra;
    int acc_cnt;

    tab[0] = 8'h80; tab[1] = 8'hFE; tab[2] = 8'h96; tab[3] = 8'h7F;
    tab[4] = 8'h01; tab[5] = 8'h69; tab[6] = 8'h0F; tab[7] = 8'hF0;

    bm.in_valid = 1'b0; bm.op = '0; bm.a = '0; bm.out_ready = 1'b0;
    bs.in_valid = 1'b0; bs.op = '0; bs.a = '0; bs.out_ready = 1'b0;

    // Reset state
    #2;
    check_eq("rst_out_valid", 32'(bm.out_valid), 32'(0));
    check_eq("rst_y", 32'(bm.y), 32'(0));
    check_eq("rst_out_changed", 32'(bm.out_changed), 32'(0));
    check_eq("rst_change_count", 32'(bm.change_count), 32'(0));
    check_eq("rst_in_ready", 32'(bm.in_ready), 32'(0));
    check_eq("rst_s_in_ready", 32'(bs.in_ready), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", 32'(bm.in_ready), 32'(1));

    // First result after reset is zero, equal to prev, so unchanged
    m_log_y.delete(); m_log_c.delete();
    step_m(1'b1, 3'd0, 24'hAACC00, 1'b1);
    check_eq("first_accept", 32'(m_acc), 32'(1));
    step_m(1'b0, 3'd0, 24'h0, 1'b1);
    check_eq("latency_ov_t1", 32'(m_ov), 32'(0));
    step_m(1'b0, 3'd0, 24'h0, 1'b1);
    check_eq("latency_ov_t2", 32'(m_ov), 32'(1));
    drain_m();
    check_eq("first_zero_chg", 32'(m_log_c.size() > 0 ? m_log_c[0] : 1'b1), 32'(0));

    // All eight ops on one operand set, back to back
    m_log_y.delete(); m_log_c.delete();
    for (int op = 0; op < 8; op++) step_m(1'b1, 3'(op), 24'hAACCF0, 1'b1);
    drain_m();
    check_eq("op_table_len", 32'(m_log_y.size()), 32'(8));
    for (int op = 0; op < 8 && op < m_log_y.size(); op++)
      check_eq($sformatf("op_table_%0d", op), 32'(m_log_y[op]), 32'(tab[op]));

    // Identical transaction twice: second one unchanged
    m_log_y.delete(); m_log_c.delete();
    step_m(1'b1, 3'd2, 24'h123456, 1'b1);
    step_m(1'b1, 3'd2, 24'h123456, 1'b1);
    drain_m();
    check_eq("dup_second_chg", 32'(m_log_c.size() == 2 ? m_log_c[1] : 1'b1), 32'(0));

    // Stall with in_valid held: two accepted, then in_ready low and y held
    acc_cnt = 0;
    y_hold = '0;
    for (int i = 0; i < 5; i++) begin
      step_m(1'b1, 3'($urandom_range(0, 7)), 24'($urandom), 1'b0);
      acc_cnt += int'(m_acc);
      if (i == 2) begin
        check_eq("stall_ov", 32'(m_ov), 32'(1));
        y_hold = m_y;
      end
      if (i >= 2) begin
        check_eq("stall_in_ready", 32'(m_ir), 32'(0));
        check_eq("stall_y_stable", 32'(m_y), 32'(y_hold));
      end
    end
    check_eq("stall_accepted", 32'(acc_cnt), 32'(2));
    step_m(1'b0, 3'd0, 24'h0, 1'b1);
    check_eq("release_ov1", 32'(m_ov), 32'(1));
    step_m(1'b0, 3'd0, 24'h0, 1'b1);
    check_eq("release_ov2", 32'(m_ov), 32'(1));
    step_m(1'b0, 3'd0, 24'h0, 1'b1);
    check_eq("release_ov3", 32'(m_ov), 32'(0));

    // Random traffic with backpressure; repeats make unchanged results likely
    rop = '0; ra = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        rop = 3'($urandom_range(0, 7));
        ra  = ($urandom_range(0, 7) == 0) ? 24'h0 : 24'($urandom);
      end
      step_m($urandom_range(0, 9) < 7, rop, ra, $urandom_range(0, 9) < 6);
    end
    step_m(1'b0, 3'd0, 24'h0, 1'b1);
    drain_m();

    // Narrow instance: NAND example, then counter saturation at 3
    step_s(1'b1, 3'd3, 16'hFF0F, 1'b1);
    check_eq("s_accept", 32'(s_acc), 32'(1));
    step_s(1'b0, 3'd0, 16'h0, 1'b1);
    check_eq("s_ov_t1", 32'(s_ov), 32'(0));
    step_s(1'b0, 3'd0, 16'h0, 1'b1);
    check_eq("s_ov_t2", 32'(s_ov), 32'(1));
    check_eq("s_nand_y", 32'(s_y), 32'(8'hF0));
    check_eq("s_nand_chg", 32'(s_chg), 32'(1));
    step_s(1'b0, 3'd0, 16'h0, 1'b1);
    check_eq("s_nand_count", 32'(bs.change_count), 32'(1));
    for (int i = 0; i < 5; i++) step_s(1'b1, 3'd7, (i % 2 == 0) ? 16'h0000 : 16'h00FF, 1'b1);
    repeat (4) step_s(1'b0, 3'd0, 16'h0, 1'b1);
    check_eq("s_saturated", 32'(bs.change_count), 32'(3));

    // Reset with the wide pipeline full
    for (int i = 0; i < 3; i++) step_m(1'b1, 3'd1, 24'hFFFFFF, 1'b0);
    check_eq("full_ov", 32'(m_ov), 32'(1));
    check_eq("full_y", 32'(m_y), 32'(8'hFF));
    @(negedge clk);
    bm.in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_eq("midrst_out_valid", 32'(bm.out_valid), 32'(0));
    check_eq("midrst_y", 32'(bm.y), 32'(0));
    check_eq("midrst_count", 32'(bm.change_count), 32'(0));
    check_eq("midrst_s_count", 32'(bs.change_count), 32'(0));
    check_eq("midrst_in_ready", 32'(bm.in_ready), 32'(0));
    m_q.delete(); m_prev = '0; m_cnt = 0;
    s_q.delete(); s_prev = '0; s_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    step_m(1'b1, 3'd4, 24'h000102, 1'b1);
    check_eq("after_rst_accept", 32'(m_acc), 32'(1));
    step_m(1'b0, 3'd0, 24'h0, 1'b1);
    check_eq("after_rst_ov_t1", 32'(m_ov), 32'(0));
    step_m(1'b0, 3'd0, 24'h0, 1'b1);
    check_eq("after_rst_ov_t2", 32'(m_ov), 32'(1));
    drain_m();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
